div_iter_unit: RTL and testbench
================================

# div_iter_unit

Iterative radix-2 integer divider implementing the RV32M DIV, DIVU, REM and REMU instructions. It sits between the divide reservation station and the common data bus. It accepts one operation at a time through a valid/ready handshake and returns the result, destination physical register, ROB id and source operands on the CDB DIV channel as a single-cycle valid pulse. Divide-by-zero and signed overflow are resolved without iterating.

## Interface
Parameters:
- PRF_WIDTH, 6, physical register tag width.
- ROB_ID_WIDTH, 5, ROB index width.
- XLEN, 32, operand width; the iteration count equals XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- div_issue_valid  in  1  reservation station presents an operation.
- div_ready  out  1  unit can accept; high only in IDLE.
- div_funct3  in  3  100=DIV, 101=DIVU, 110=REM, 111=REMU.
- div_rs1_in, div_rs2_in  in  XLEN  dividend, divisor.
- div_prd_in  in  PRF_WIDTH  destination physical register.
- div_rob_id_in  in  ROB_ID_WIDTH  ROB index.
- flush  in  1  branch/JAL flush; kills any in-flight operation.
- div_output_valid  out  1  one-cycle result pulse to the CDB.
- div_output_data  out  XLEN  quotient or remainder.
- div_prd_s  out  PRF_WIDTH  latched destination tag.
- div_rob_id  out  ROB_ID_WIDTH  latched ROB id.
- div_rs1_data, div_rs2_data  out  XLEN  latched operands, for the monitor.

The output fields map one-to-one onto res_station_div_out_s.

## Operation
- **States:** IDLE, CALC, DONE.
- **Acceptance:** occurs when div_issue_valid && div_ready && !flush at the clock edge. At acceptance the unit latches funct3, operands, prd and rob_id.
- **Signed ops (DIV/REM):**
  - Operands are replaced by their absolute values.
  - quot_neg = sign(rs1) XOR sign(rs2).
  - rem_neg = sign(rs1).
- **Unsigned ops:** operands are used as-is, with both sign flags at 0.
- **Special cases (checked at acceptance, next state DONE):**
  - Divisor == 0: quotient = all ones; remainder = rs1 (original, unmodified).
  - Signed only, rs1 == 0x80000000 and rs2 == 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- **Normal case:** next state CALC with iteration counter = XLEN-1.
- **Each CALC cycle (restoring step):**
  - trial = {rem[XLEN-2:0], quot[XLEN-1]} − divisor, computed XLEN+1 bits wide.
  - If trial is non-negative: rem = trial[XLEN-1:0], and shift 1 into the quotient LSB.
  - Otherwise: rem is shifted, and shift 0 into the quotient LSB.
  - The quotient register starts holding |dividend| and shifts left each step.
- **Leaving CALC:** when the counter reaches 0, go to DONE. Apply sign fix-ups on entry to DONE:
  - quotient = quot_neg ? −q : q.
  - remainder = rem_neg ? −r : r.
- **DONE:**
  - div_output_valid = 1 for exactly one cycle.
  - div_output_data = quotient for funct3[1]==0, remainder for funct3[1]==1.
  - Next state is IDLE.
- **Output fields outside DONE:** div_output_data, div_prd_s, div_rob_id, div_rs1_data and div_rs2_data hold their last values. They are don't-care while div_output_valid=0.
- **Flush:**
  - In any state, flush forces the next state to IDLE.
  - div_output_valid is gated low combinationally in the flush cycle.
  - An issue coinciding with flush is not accepted.

## Timing
- **Reset:** state IDLE, counter 0, all data registers 0. Outputs: div_ready=1, div_output_valid=0, all other outputs 0.
- **Normal latency:** acceptance at edge N puts the unit in CALC for cycles N+1 … N+XLEN. div_output_valid is high in cycle N+XLEN+1 (cycle N+33 for XLEN=32).
- **Special-case latency:** div_output_valid is high in cycle N+1.
- **div_ready:** low from the cycle after acceptance through DONE. It returns high in the cycle after the valid pulse.
- **Throughput:** minimum issue spacing is XLEN+2 cycles for normal ops, and 2 cycles for special cases.
- **Downstream:** no backpressure. The CDB DIV channel always consumes the pulse.
- **Asynchronous reset mid-CALC:** returns the unit immediately to reset values, with no output pulse.

## Test plan
- DIVU 100 / 7 → valid in cycle N+33 with data 14; REMU same operands → 2; prd_s and rob_id echo the issued values.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3); REM same → 0xFFFFFFFF (−1); REM 7 / −2 → 1.
- DIV 5 / 0 → 0xFFFFFFFF in cycle N+1; REMU 5 / 0 → 5; div_ready is high again in cycle N+2.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle N+1; REM same operands → 0.
- Issue DIVU 1000/3, assert flush in CALC cycle 10 → no valid pulse ever for it; div_ready=1 the next cycle; a new DIVU 9/3 then returns 3 after 33 cycles.
- Hold div_issue_valid high with four back-to-back ops → each is accepted exactly one cycle after the previous valid pulse; results arrive in order with correct rob_id; div_ready is never high outside IDLE.

Source files
------------

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_iter_unit #(
  parameter int PRF_WIDTH    = 6,
  parameter int ROB_ID_WIDTH = 5,
  parameter int XLEN         = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    div_issue_valid,
  output logic                    div_ready,
  input  logic [2:0]              div_funct3,
  input  logic [XLEN-1:0]         div_rs1_in,
  input  logic [XLEN-1:0]         div_rs2_in,
  input  logic [PRF_WIDTH-1:0]    div_prd_in,
  input  logic [ROB_ID_WIDTH-1:0] div_rob_id_in,
  input  logic                    flush,
  output logic                    div_output_valid,
  output logic [XLEN-1:0]         div_output_data,
  output logic [PRF_WIDTH-1:0]    div_prd_s,
  output logic [ROB_ID_WIDTH-1:0] div_rob_id,
  output logic [XLEN-1:0]         div_rs1_data,
  output logic [XLEN-1:0]         div_rs2_data
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              rem_sel;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   divisor;
  logic              quot_neg;
  logic              rem_neg;

  logic              signed_op;
  logic              rs1_neg;
  logic              rs2_neg;
  logic [XLEN-1:0]   abs_rs1;
  logic [XLEN-1:0]   abs_rs2;
  logic              div_zero;
  logic              overflow;
  logic [XLEN-1:0]   special_data;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quot_next;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;

  // Non-divide funct3 encodings (bit 2 clear) are treated as unsigned.
  assign signed_op = div_funct3[2] & ~div_funct3[0];
  assign rs1_neg   = signed_op & div_rs1_in[XLEN-1];
  assign rs2_neg   = signed_op & div_rs2_in[XLEN-1];
  assign abs_rs1   = rs1_neg ? -div_rs1_in : div_rs1_in;
  assign abs_rs2   = rs2_neg ? -div_rs2_in : div_rs2_in;
  assign div_zero  = (div_rs2_in == '0);
  assign overflow  = signed_op && (div_rs1_in == {1'b1, {(XLEN-1){1'b0}}})
                     && (div_rs2_in == '1);

  always_comb begin
    special_data = '0;
    if (div_zero)
      special_data = div_funct3[1] ? div_rs1_in : '1;
    else if (overflow)
      special_data = div_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Full-width partial remainder keeps large unsigned divisors exact.
  assign trial     = {rem, quot[XLEN-1]} - {1'b0, divisor};
  assign rem_next  = trial[XLEN] ? {rem[XLEN-2:0], quot[XLEN-1]} : trial[XLEN-1:0];
  assign quot_next = {quot[XLEN-2:0], ~trial[XLEN]};
  assign quot_fix  = quot_neg ? -quot_next : quot_next;
  assign rem_fix   = rem_neg ? -rem_next : rem_next;

  assign div_ready        = (state == IDLE);
  assign div_output_valid = (state == DONE) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      rem_sel         <= 1'b0;
      quot            <= '0;
      rem             <= '0;
      divisor         <= '0;
      quot_neg        <= 1'b0;
      rem_neg         <= 1'b0;
      div_output_data <= '0;
      div_prd_s       <= '0;
      div_rob_id      <= '0;
      div_rs1_data    <= '0;
      div_rs2_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_issue_valid && !flush) begin
            rem_sel      <= div_funct3[1];
            div_prd_s    <= div_prd_in;
            div_rob_id   <= div_rob_id_in;
            div_rs1_data <= div_rs1_in;
            div_rs2_data <= div_rs2_in;
            quot_neg     <= rs1_neg ^ rs2_neg;
            rem_neg      <= rs1_neg;
            if (div_zero || overflow) begin
              div_output_data <= special_data;
              state           <= DONE;
            end else begin
              quot    <= abs_rs1;
              rem     <= '0;
              divisor <= abs_rs2;
              cnt     <= CNT_W'(XLEN - 1);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            quot <= quot_next;
            rem  <= rem_next;
            if (cnt == '0) begin
              div_output_data <= rem_sel ? rem_fix : quot_fix;
              state           <= DONE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - directed self-checking bench for div_iter_unit
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_issue_valid = 1'b0;
  logic        div_ready;
  logic [2:0]  div_funct3 = 3'b0;
  logic [31:0] div_rs1_in = '0;
  logic [31:0] div_rs2_in = '0;
  logic [5:0]  div_prd_in = '0;
  logic [4:0]  div_rob_id_in = '0;
  logic        flush = 1'b0;
  logic        div_output_valid;
  logic [31:0] div_output_data;
  logic [5:0]  div_prd_s;
  logic [4:0]  div_rob_id;
  logic [31:0] div_rs1_data;
  logic [31:0] div_rs2_data;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  div_iter_unit #(.PRF_WIDTH(6), .ROB_ID_WIDTH(5), .XLEN(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .div_issue_valid  (div_issue_valid),
    .div_ready        (div_ready),
    .div_funct3       (div_funct3),
    .div_rs1_in       (div_rs1_in),
    .div_rs2_in       (div_rs2_in),
    .div_prd_in       (div_prd_in),
    .div_rob_id_in    (div_rob_id_in),
    .flush            (flush),
    .div_output_valid (div_output_valid),
    .div_output_data  (div_output_data),
    .div_prd_s        (div_prd_s),
    .div_rob_id       (div_rob_id),
    .div_rs1_data     (div_rs1_data),
    .div_rs2_data     (div_rs2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] prd, input logic [4:0] rob);
    div_funct3      = f3;
    div_rs1_in      = a;
    div_rs2_in      = b;
    div_prd_in      = prd;
    div_rob_id_in   = rob;
    div_issue_valid = 1'b1;
  endtask

  // Called just after a negedge with the unit idle; returns just after a negedge.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] prd, input logic [4:0] rob,
                        input logic [31:0] exp_data, input int exp_lat);
    int lat;
    int bad_ready;
    lat = 0;
    bad_ready = 0;
    drive(f3, a, b, prd, rob);
    @(posedge clk);
    #1 div_issue_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (div_ready) bad_ready++;
      if (div_output_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, div_output_data, exp_data);
    check({tag, " prd"}, 32'(div_prd_s), 32'(prd));
    check({tag, " rob"}, 32'(div_rob_id), 32'(rob));
    check({tag, " rs1"}, div_rs1_data, a);
    check({tag, " rs2"}, div_rs2_data, b);
    check({tag, " ready busy"}, 32'(bad_ready), 32'd0);
    @(negedge clk);
    check({tag, " ready after"}, 32'(div_ready), 32'd1);
    check({tag, " single pulse"}, 32'(div_output_valid), 32'd0);
  endtask

  logic [2:0]  bb_f3  [4] = '{F_DIVU, F_REM, F_DIV, F_REMU};
  logic [31:0] bb_a   [4] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF};
  logic [31:0] bb_b   [4] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'h80000001};
  logic [31:0] bb_exp [4] = '{32'd14, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h7FFFFFFE};

  initial begin
    int pulses;
    int cyc;
    int issued;
    int got;
    int last_pulse;
    int ready_hi;

    repeat (2) @(negedge clk);
    check("rst ready", 32'(div_ready), 32'd1);
    check("rst valid", 32'(div_output_valid), 32'd0);
    check("rst data", div_output_data, 32'd0);
    check("rst prd", 32'(div_prd_s), 32'd0);
    check("rst rob", 32'(div_rob_id), 32'd0);
    check("rst rs1", div_rs1_data, 32'd0);
    check("rst rs2", div_rs2_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("divu 100/7",    F_DIVU, 32'd100,        32'd7,          6'd5,  5'd3,  32'd14,         33);
    run_op("remu 100/7",    F_REMU, 32'd100,        32'd7,          6'd12, 5'd17, 32'd2,          33);
    run_op("div -7/2",      F_DIV,  32'hFFFFFFF9,   32'd2,          6'd1,  5'd2,  32'hFFFFFFFD,   33);
    run_op("rem -7/2",      F_REM,  32'hFFFFFFF9,   32'd2,          6'd2,  5'd4,  32'hFFFFFFFF,   33);
    run_op("rem 7/-2",      F_REM,  32'd7,          32'hFFFFFFFE,   6'd63, 5'd31, 32'd1,          33);
    run_op("div 5/0",       F_DIV,  32'd5,          32'd0,          6'd7,  5'd8,  32'hFFFFFFFF,   1);
    run_op("remu 5/0",      F_REMU, 32'd5,          32'd0,          6'd9,  5'd10, 32'd5,          1);
    run_op("rem -5/0",      F_REM,  32'hFFFFFFFB,   32'd0,          6'd3,  5'd1,  32'hFFFFFFFB,   1);
    run_op("div ovf",       F_DIV,  32'h80000000,   32'hFFFFFFFF,   6'd11, 5'd12, 32'h80000000,   1);
    run_op("rem ovf",       F_REM,  32'h80000000,   32'hFFFFFFFF,   6'd13, 5'd14, 32'd0,          1);
    run_op("divu big",      F_DIVU, 32'hFFFFFFFF,   32'h80000001,   6'd20, 5'd21, 32'd1,          33);
    run_op("divu max/1",    F_DIVU, 32'hFFFFFFFF,   32'd1,          6'd22, 5'd23, 32'hFFFFFFFF,   33);
    run_op("div min/2",     F_DIV,  32'h80000000,   32'd2,          6'd24, 5'd25, 32'hC0000000,   33);

    // Flush in the tenth CALC cycle kills the operation.
    drive(F_DIVU, 32'd1000, 32'd3, 6'd30, 5'd6);
    @(posedge clk);
    #1 div_issue_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush ready", 32'(div_ready), 32'd1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_output_valid) pulses++;
    end
    check("flush no pulse", 32'(pulses), 32'd0);
    run_op("divu 9/3", F_DIVU, 32'd9, 32'd3, 6'd31, 5'd7, 32'd3, 33);

    // Flush during DONE gates the pulse combinationally.
    drive(F_DIV, 32'd5, 32'd0, 6'd4, 5'd5);
    @(posedge clk);
    #1 begin div_issue_valid = 1'b0; flush = 1'b1; end
    #1 check("flush done gate", 32'(div_output_valid), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush done ready", 32'(div_ready), 32'd1);

    // Issue coinciding with flush is ignored.
    drive(F_DIV, 32'd5, 32'd0, 6'd4, 5'd5);
    flush = 1'b1;
    @(posedge clk);
    #1 begin div_issue_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("issue+flush ignored", 32'({div_ready, div_output_valid}), 32'b10);

    // Back-to-back issue with valid held high.
    cyc = 0; issued = 0; got = 0; last_pulse = -100; ready_hi = 0;
    while (got < 4 && cyc < 400) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (div_output_valid) begin
        check("b2b data", div_output_data, bb_exp[got]);
        check("b2b rob", 32'(div_rob_id), 32'(got + 1));
        last_pulse = cyc;
        got++;
      end
      if (issued < 4) begin
        drive(bb_f3[issued], bb_a[issued], bb_b[issued], 6'(issued + 40), 5'(issued + 1));
        if (div_ready) begin
          ready_hi++;
          if (issued > 0) check("b2b spacing", 32'(cyc - last_pulse), 32'd1);
          issued++;
        end
      end else begin
        div_issue_valid = 1'b0;
        if (div_ready) ready_hi++;
      end
    end
    div_issue_valid = 1'b0;
    check("b2b all results", 32'(got), 32'd4);
    check("b2b ready cycles", 32'(ready_hi), 32'd4);
    @(negedge clk);

    // Asynchronous reset in mid-CALC.
    drive(F_DIVU, 32'd1000, 32'd3, 6'd50, 5'd9);
    @(posedge clk);
    #1 div_issue_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 begin
      check("async rst ready", 32'(div_ready), 32'd1);
      check("async rst data", div_output_data, 32'd0);
      check("async rst rob", 32'(div_rob_id), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_output_valid) pulses++;
    end
    check("async rst no pulse", 32'(pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
